// File: rtl/flappy_pkg.sv
// Shared types and constants for the Flappy Bird obstacle engine.
package flappy_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDead = 2'd2
  } game_state_t;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic signed [11:0] x;
    logic [9:0]         gap_top;
  } pipe_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/pipe_engine_if.sv
// Frame/pixel inputs and game outputs shared between the display logic and pipe_engine.
interface pipe_engine_if;
  import flappy_pkg::*;

  logic        frame_tick;
  logic        start;
  logic [9:0]  hcol;
  logic [9:0]  vrow;
  logic        active;
  logic [9:0]  bird_y;
  logic        pipe_pixel;
  game_state_t state;
  logic [15:0] score;
  logic        busy;

  modport master (
    output frame_tick, start, hcol, vrow, active, bird_y,
    input  pipe_pixel, state, score, busy
  );

  modport slave (
    input  frame_tick, start, hcol, vrow, active, bird_y,
    output pipe_pixel, state, score, busy
  );

endinterface

// File: rtl/lfsr16.sv
// Enable-stepped 16-bit Galois LFSR; exposes the low OutW bits of its state.
module lfsr16 import flappy_pkg::*; #(
  parameter logic [15:0] SEED = LFSR_SEED,
  parameter int unsigned OutW = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en_i,
  output logic [OutW-1:0] rnd_o
);

  logic [15:0] state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SEED;
    end else if (en_i) begin
      state_q <= lfsr_next(state_q);
    end
  end

  assign rnd_o = state_q[OutW-1:0];

endmodule

// File: rtl/pipe_engine.sv
// Obstacle engine: N scrolling pipes, LFSR gap placement, bird collision, score and game FSM.
// Optional speed ramp with score is enabled by defining PIPE_SPEEDUP_EN.
module pipe_engine #(
  parameter int NUM_PIPES = 3,
  parameter int PIPE_W    = 70,
  parameter int GAP_H     = 120,
  parameter int GAP_MIN   = 40,
  parameter int GAP_SPAN  = 100,
  parameter int SPACING   = 256,
  parameter int START_X   = 640,
  parameter int RESET_X   = 768,
  parameter int SPEED     = 2,
  parameter int MAX_SPEED = 6,
  parameter int BIRD_X    = 100,
  parameter int BIRD_W    = 34,
  parameter int BIRD_H    = 24,
  parameter int SCREEN_H  = flappy_pkg::SCREEN_H
) (
  input logic           clk,
  input logic           reset_n,
  pipe_engine_if.slave  bus
);
  import flappy_pkg::*;

  localparam int IdxW   = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
  localparam int GapMax = GAP_MIN + GAP_SPAN - 1;
  localparam int SpeedW = $clog2(((SPEED > MAX_SPEED) ? SPEED : MAX_SPEED) + 1);
  localparam logic signed [12:0] PipeW13 = 13'(PIPE_W);
  localparam logic signed [12:0] BirdX13 = 13'(BIRD_X);
  localparam logic signed [12:0] XWrap   = 13'(-PIPE_W);

  function automatic pipe_t init_pipe(input int i);
    pipe_t p;
    int    g;
    g = GAP_MIN + i * 16;
    if (g > GapMax) g = GapMax;
    p.x       = 12'(START_X + i * SPACING);
    p.gap_top = 10'(g);
    return p;
  endfunction

  game_state_t       state_q;
  pipe_t             pipes_q [NUM_PIPES];
  logic              busy_q, collide_q, pipe_pixel_q;
  logic [IdxW-1:0]   idx_q;
  logic [15:0]       score_q;
  logic [SpeedW-1:0] speed_q;

  logic [6:0]        rnd;
  pipe_t             cur_pipe, step_pipe;
  logic signed [12:0] old_x, new_x, fin_x, speed_s;
  logic [7:0]        r_red;
  logic              wrap, passed;

  lfsr16 #(.SEED(LFSR_SEED), .OutW(7)) u_lfsr (
    .clk    (clk),
    .reset_n(reset_n),
    .en_i   (busy_q && wrap),
    .rnd_o  (rnd)
  );

  assign speed_s = 13'(speed_q);

  // Next position of the pipe currently selected by the walk index.
  always_comb begin
    cur_pipe  = pipes_q[idx_q];
    old_x     = {cur_pipe.x[11], cur_pipe.x};
    new_x     = old_x - speed_s;
    wrap      = (new_x <= XWrap);
    r_red     = ({1'b0, rnd} >= 8'(GAP_SPAN)) ? ({1'b0, rnd} - 8'(GAP_SPAN)) : {1'b0, rnd};
    step_pipe = cur_pipe;
    if (wrap) begin
      step_pipe.x       = 12'(RESET_X);
      step_pipe.gap_top = 10'(GAP_MIN) + {2'b00, r_red};
    end else begin
      step_pipe.x = new_x[11:0];
    end
    fin_x  = {step_pipe.x[11], step_pipe.x};
    passed = (old_x + PipeW13 > BirdX13) && (fin_x + PipeW13 <= BirdX13);
  end

  logic [NUM_PIPES-1:0] hit;
  logic signed [12:0]   hcol_s;
  logic [10:0]          vrow_e, bird_bot;
  logic                 in_bird, screen_hit;

  assign hcol_s     = {3'b000, bus.hcol};
  assign vrow_e     = {1'b0, bus.vrow};
  assign bird_bot   = {1'b0, bus.bird_y} + 11'(BIRD_H);
  assign in_bird    = (bus.hcol >= 10'(BIRD_X)) && ({1'b0, bus.hcol} < 11'(BIRD_X + BIRD_W)) &&
                      (bus.vrow >= bus.bird_y) && (vrow_e < bird_bot);
  assign screen_hit = (bird_bot >= 11'(SCREEN_H));

  for (genvar g = 0; g < NUM_PIPES; g++) begin : g_hit
    logic signed [12:0] px;
    logic [10:0]        gt;
    assign px     = {pipes_q[g].x[11], pipes_q[g].x};
    assign gt     = {1'b0, pipes_q[g].gap_top};
    assign hit[g] = (hcol_s >= px) && (hcol_s < px + PipeW13) &&
                    ((vrow_e < gt) || (vrow_e >= gt + 11'(GAP_H)));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      busy_q       <= 1'b0;
      idx_q        <= '0;
      score_q      <= '0;
      collide_q    <= 1'b0;
      speed_q      <= SpeedW'(SPEED);
      pipe_pixel_q <= 1'b0;
      for (int i = 0; i < NUM_PIPES; i++) pipes_q[i] <= init_pipe(i);
    end else begin
      pipe_pixel_q <= bus.active && (state_q != StIdle) && (|hit);
      if (bus.active && (state_q == StRun) && in_bird && (|hit)) collide_q <= 1'b1;
      unique case (state_q)
        StIdle: if (bus.start) state_q <= StRun;
        StRun: begin
          if (!busy_q) begin
            if (bus.frame_tick) begin
              busy_q <= 1'b1;
              idx_q  <= '0;
              if (screen_hit) collide_q <= 1'b1;
            end
          end else begin
            pipes_q[idx_q] <= step_pipe;
            if (passed && (score_q != 16'hFFFF)) begin
              score_q <= score_q + 16'd1;
`ifdef PIPE_SPEEDUP_EN
              if ((score_q[2:0] == 3'd7) && (speed_q < SpeedW'(MAX_SPEED))) begin
                speed_q <= speed_q + SpeedW'(1);
              end
`endif
            end
            if (idx_q == IdxW'(NUM_PIPES - 1)) begin
              busy_q <= 1'b0;
              if (collide_q) state_q <= StDead;
            end else begin
              idx_q <= idx_q + IdxW'(1);
            end
          end
        end
        StDead: begin
          // Restart reinitialises the round but keeps the LFSR running so rounds differ.
          if (bus.start) begin
            state_q   <= StIdle;
            score_q   <= '0;
            collide_q <= 1'b0;
            speed_q   <= SpeedW'(SPEED);
            for (int i = 0; i < NUM_PIPES; i++) pipes_q[i] <= init_pipe(i);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.pipe_pixel = pipe_pixel_q;
  assign bus.state      = state_q;
  assign bus.score      = score_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_pipe_engine.sv
// Self-checking bench for pipe_engine against a frame-level behavioural game model.
module tb_pipe_engine;
  import flappy_pkg::*;

  localparam int N = 3, PW = 70, GH = 120, GMIN = 40, GSPAN = 100, SP = 256;
  localparam int SX = 640, RX = 768, SPD = 2, MAXSPD = 6, BX = 100, BW = 34, BH = 24, SH = 480;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #10 clk = ~clk;

  pipe_engine_if bus ();

  pipe_engine dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model: 0=idle 1=run 2=dead
  int          m_x [N];
  int          m_gt[N];
  int          m_score, m_speed, m_state;
  bit          m_coll;
  logic [15:0] m_lfsr;
  int          bird;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  function automatic void model_reset(input bit hard);
    for (int i = 0; i < N; i++) begin
      m_x[i]  = SX + i * SP;
      m_gt[i] = (GMIN + i * 16 > GMIN + GSPAN - 1) ? GMIN + GSPAN - 1 : GMIN + i * 16;
    end
    m_score = 0;
    m_speed = SPD;
    m_coll  = 0;
    m_state = 0;
    if (hard) m_lfsr = 16'hACE1;
  endfunction

  function automatic bit model_hit(input int h, input int v);
    bit any = 0;
    for (int i = 0; i < N; i++)
      if (h >= m_x[i] && h < m_x[i] + PW && (v < m_gt[i] || v >= m_gt[i] + GH)) any = 1;
    return any;
  endfunction

  function automatic void model_frame();
    int old, r;
    if (m_state != 1) return;
    if (bird + BH >= SH) m_coll = 1;
    for (int i = 0; i < N; i++) begin
      old    = m_x[i];
      m_x[i] = old - m_speed;
      if (m_x[i] <= -PW) begin
        r       = int'(m_lfsr[6:0]);
        m_x[i]  = RX;
        m_gt[i] = GMIN + ((r >= GSPAN) ? r - GSPAN : r);
        m_lfsr  = lfsr_step(m_lfsr);
      end
      if (old + PW > BX && m_x[i] + PW <= BX && m_score < 65535) begin
        m_score++;
`ifdef PIPE_SPEEDUP_EN
        if (m_score % 8 == 0 && m_speed < MAXSPD) m_speed++;
`endif
      end
    end
    if (m_coll) m_state = 2;
  endfunction

  task automatic probe(input int h, input int v, input string tag);
    bit exp;
    bus.hcol   = 10'(h);
    bus.vrow   = 10'(v);
    bus.active = 1'b1;
    exp = (m_state != 0) && model_hit(h, v);
    if (m_state == 1 && h >= BX && h < BX + BW && v >= bird && v < bird + BH && model_hit(h, v))
      m_coll = 1;
    @(posedge clk); #1;
    bus.active = 1'b0;
    check(tag, 32'(bus.pipe_pixel), 32'(exp));
  endtask

  task automatic rand_probe();
    int h;
    h = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, BX - 1))
                                    : int'($urandom_range(BX + BW, 1023));
    probe(h, int'($urandom_range(0, SH - 1)), "rand_pix");
  endtask

  task automatic frame(input bit dbl, input string tag);
    int cyc, exp_cyc;
    bus.bird_y = 10'(bird);
    exp_cyc = (m_state == 1) ? N : 0;
    model_frame();
    bus.frame_tick = 1'b1;
    @(posedge clk); #1;
    bus.frame_tick = 1'b0;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 4 * N + 4) begin
      if (dbl && cyc == 0) bus.frame_tick = 1'b1;
      @(posedge clk); #1;
      bus.frame_tick = 1'b0;
      cyc++;
    end
    check({tag, " busy_cycles"}, 32'(cyc), 32'(exp_cyc));
    check({tag, " state"}, 32'(bus.state), 32'(m_state));
    check({tag, " score"}, 32'(bus.score), 32'(m_score));
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (m_state == 0) m_state = 1;
    else if (m_state == 2) model_reset(0);
  endtask

  task automatic run_until_over(input int col);
    int f = 0;
    while (!(m_x[0] <= col && m_x[0] + PW > col) && !(m_x[1] <= col && m_x[1] + PW > col) &&
           !(m_x[2] <= col && m_x[2] + PW > col) && f < 600) begin
      frame(1'b0, "approach");
      rand_probe();
      f++;
    end
    check("approach bound", 32'(f < 600), 32'(1));
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.start      = 1'b0;
    bus.hcol       = '0;
    bus.vrow       = '0;
    bus.active     = 1'b0;
    bird           = 200;
    bus.bird_y     = 10'(bird);
    model_reset(1);

    repeat (3) @(posedge clk);
    #1;
    check("rst state", 32'(bus.state), 32'(m_state));
    check("rst score", 32'(bus.score), 32'(m_score));
    check("rst busy", 32'(bus.busy), 32'(0));
    check("rst pix", 32'(bus.pipe_pixel), 32'(0));
    reset_n = 1'b1;

    probe(640, 0, "idle pix");

    // start and frame_tick together in IDLE: start wins, no walk
    bus.start = 1'b1;
    bus.frame_tick = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.frame_tick = 1'b0;
    m_state = 1;
    check("start+tick state", 32'(bus.state), 32'(m_state));
    @(posedge clk); #1;
    check("start+tick busy", 32'(bus.busy), 32'(0));

    frame(1'b0, "first");
    probe(638, 0, "p0 left");
    probe(637, 0, "p0 left-1");
    probe(707, 0, "p0 right");
    probe(708, 0, "p0 right+1");
    probe(638, 100, "p0 gap");
    probe(638, 200, "p0 below gap");
    probe(894, 55, "p1 gap-1");
    probe(894, 56, "p1 gap");

    pulse_start();
    check("start in run", 32'(bus.state), 32'(m_state));

    // long run: pipe 0 crosses the bird and wraps with an LFSR-placed gap
    for (int f = 0; f < 359; f++) begin
      bird = int'($urandom_range(0, 400));
      frame(($urandom_range(0, 7) == 0), "run");
      rand_probe();
      rand_probe();
    end
    probe(m_x[0], m_gt[0] - 1, "wrap gap-1");
    probe(m_x[0], m_gt[0], "wrap gap top");
    probe(m_x[0], m_gt[0] + GH - 1, "wrap gap bot");
    probe(m_x[0], m_gt[0] + GH, "wrap below gap");

    // asynchronous reset in the middle of a walk
    bus.hcol   = 10'(m_x[0]);
    bus.vrow   = '0;
    bus.active = 1'b1;
    bus.frame_tick = 1'b1;
    @(posedge clk); #1;
    bus.frame_tick = 1'b0;
    @(posedge clk); #1;
    check("pre_rst busy", 32'(bus.busy), 32'(1));
    check("pre_rst pix", 32'(bus.pipe_pixel), 32'(model_hit(m_x[0], 0)));
    #3 reset_n = 1'b0;
    #1;
    check("async rst busy", 32'(bus.busy), 32'(0));
    check("async rst state", 32'(bus.state), 32'(0));
    check("async rst score", 32'(bus.score), 32'(0));
    check("async rst pix", 32'(bus.pipe_pixel), 32'(0));
    bus.active = 1'b0;
    model_reset(1);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // bird box collision
    pulse_start();
    bird = 0;
    run_until_over(110);
    probe(110, 5, "bird box hit");
    frame(1'b0, "collide");
    frame(1'b0, "dead frozen");
    probe(110, 5, "dead pix");

    pulse_start();
    check("restart idle state", 32'(bus.state), 32'(m_state));
    check("restart score", 32'(bus.score), 32'(m_score));
    pulse_start();
    probe(640, 0, "reinit p0");
    probe(639, 0, "reinit p0-1");
    frame(1'b0, "second round");
    probe(638, 0, "second round p0");

    // screen floor death
    bird = 460;
    frame(1'b0, "floor");
    check("floor dead", 32'(bus.state), 32'(2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
